// File: rtl/svc_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling, one-deep
// holding register with valid/ready handshake, frame-error and overrun pulses.
module svc_uart_rx #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       urx_in,
  output logic       urx_valid,
  output logic [7:0] urx_data,
  input  logic       urx_ready,
  output logic       urx_frame_err,
  output logic       urx_overrun,
  output logic       urx_busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("svc_uart_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  // state     | meaning
  // IDLE      | waiting for falling edge on rx_s
  // START     | counting to start-bit middle, rejecting glitches
  // DATA      | sampling 8 data bits, LSB first
  // STOP      | counting to stop-bit middle, then deliver or flag error
  // WAIT_HIGH | after a framing error, waiting for line to return high
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic             sync1_q, rx_s_q, rx_prev_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             deliver;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          cnt_d   = CNT_HALF;
          state_d = START;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_FULL;
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = CNT_FULL;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // leaving mid-stop-bit lets the next start edge follow with no idle gap
          deliver = rx_s_q;
          ferr_d  = !rx_s_q;
          state_d = rx_s_q ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (deliver) begin
      if (!valid_q || urx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && urx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= urx_in;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign urx_valid     = valid_q;
  assign urx_data      = data_q;
  assign urx_frame_err = ferr_q;
  assign urx_overrun   = ovr_q;
  assign urx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_svc_uart_rx.sv
// Directed bench for svc_uart_rx at 16 clocks per bit: framing, back-to-back,
// overrun, framing error, glitch rejection and mid-frame reset.
module tb_svc_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       urx_in;
  logic       urx_valid;
  logic [7:0] urx_data;
  logic       urx_ready;
  logic       urx_frame_err;
  logic       urx_overrun;
  logic       urx_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cyc = -1;
  logic       valid_prev = 1'b0;
  logic [7:0] cap[$];
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         both_cnt = 0;

  svc_uart_rx #(.CLOCK_FREQ(1600), .BAUD_RATE(100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .urx_in        (urx_in),
    .urx_valid     (urx_valid),
    .urx_data      (urx_data),
    .urx_ready     (urx_ready),
    .urx_frame_err (urx_frame_err),
    .urx_overrun   (urx_overrun),
    .urx_busy      (urx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (urx_valid && !valid_prev && rise_cyc < 0) rise_cyc = cyc;
    valid_prev = urx_valid;
    if (urx_valid && urx_ready) cap.push_back(urx_data);
    if (urx_frame_err) ferr_cnt++;
    if (urx_overrun) ovr_cnt++;
    if (urx_frame_err && urx_overrun) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cap_at(input int i);
    if (i < cap.size()) return cap[i];
    return 8'hxx;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    cap.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
    rise_cyc = -1;
  endtask

  // Leaves the line at stop_v; the caller restores idle after a low stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_clks);
    urx_in    = 1'b0;
    start_cyc = cyc;
    wait_clks(16);
    for (int i = 0; i < 8; i++) begin
      urx_in = b[i];
      wait_clks(16);
    end
    urx_in = stop_v;
    wait_clks(stop_clks);
  endtask

  initial begin
    rst_n     = 1'b0;
    urx_in    = 1'b1;
    urx_ready = 1'b0;
    wait_clks(3);
    chk("rst_valid", urx_valid, 0);
    chk("rst_data", urx_data, 8'h00);
    chk("rst_ferr", urx_frame_err, 0);
    chk("rst_ovr", urx_overrun, 0);
    chk("rst_busy", urx_busy, 0);
    rst_n = 1'b1;
    wait_clks(5);

    // single frame 0x55
    urx_ready = 1'b1;
    clr_mon();
    send_frame(8'h55, 1'b1, 16);
    wait_clks(4);
    chk("single_count", cap.size(), 1);
    chk("single_data", cap_at(0), 8'h55);
    chk("single_latency", rise_cyc - start_cyc, 155);
    chk("single_ferr", ferr_cnt, 0);
    chk("single_ovr", ovr_cnt, 0);
    chk("single_busy", urx_busy, 0);
    chk("single_valid_clr", urx_valid, 0);

    // back-to-back, zero idle
    clr_mon();
    send_frame(8'hA5, 1'b1, 16);
    send_frame(8'h3C, 1'b1, 16);
    wait_clks(4);
    chk("b2b_count", cap.size(), 2);
    chk("b2b_first", cap_at(0), 8'hA5);
    chk("b2b_second", cap_at(1), 8'h3C);
    chk("b2b_ferr", ferr_cnt, 0);

    // overrun with consumer stalled
    urx_ready = 1'b0;
    clr_mon();
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 16);
    wait_clks(4);
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_valid_held", urx_valid, 1);
    chk("ovr_data_held", urx_data, 8'h11);
    chk("ovr_no_accept", cap.size(), 0);
    urx_ready = 1'b1;
    wait_clks(2);
    chk("ovr_consumed_count", cap.size(), 1);
    chk("ovr_consumed_data", cap_at(0), 8'h11);
    chk("ovr_valid_clr", urx_valid, 0);

    // framing error: stop bit held low for 3 bit times
    clr_mon();
    send_frame(8'h7E, 1'b0, 48);
    chk("ferr_pulses", ferr_cnt, 1);
    chk("ferr_busy_wait", urx_busy, 1);
    chk("ferr_no_byte", cap.size(), 0);
    chk("ferr_valid", urx_valid, 0);
    urx_in = 1'b1;
    wait_clks(4);
    chk("ferr_busy_idle", urx_busy, 0);
    chk("ferr_ovr", ovr_cnt, 0);

    // start-bit glitch of 4 clocks
    clr_mon();
    urx_in = 1'b0;
    wait_clks(4);
    chk("glitch_busy_start", urx_busy, 1);
    urx_in = 1'b1;
    wait_clks(20);
    chk("glitch_busy_idle", urx_busy, 0);
    chk("glitch_no_byte", cap.size(), 0);
    chk("glitch_ferr", ferr_cnt, 0);
    chk("glitch_ovr", ovr_cnt, 0);

    // reset during data bit 3 of 0xC3, then a clean 0xC3
    clr_mon();
    urx_in = 1'b0;
    wait_clks(16);
    urx_in = 1'b1; wait_clks(16);
    urx_in = 1'b1; wait_clks(16);
    urx_in = 1'b0; wait_clks(16);
    urx_in = 1'b0; wait_clks(8);
    chk("mrst_busy_before", urx_busy, 1);
    rst_n  = 1'b0;
    urx_in = 1'b1;
    #1;
    chk("mrst_valid", urx_valid, 0);
    chk("mrst_data", urx_data, 8'h00);
    chk("mrst_ferr", urx_frame_err, 0);
    chk("mrst_ovr", urx_overrun, 0);
    chk("mrst_busy", urx_busy, 0);
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(20);
    chk("mrst_idle_busy", urx_busy, 0);
    chk("mrst_no_byte", cap.size(), 0);
    chk("mrst_no_ferr", ferr_cnt, 0);
    send_frame(8'hC3, 1'b1, 16);
    wait_clks(4);
    chk("mrst_next_count", cap.size(), 1);
    chk("mrst_next_data", cap_at(0), 8'hC3);
    chk("mrst_next_ferr", ferr_cnt, 0);

    chk("never_both_pulse", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/svc_uart_rx.md
SVC_UART_RX -- requirements
Module: svc_uart_rx

Interface
REQ-001 Parameter CLOCK_FREQ, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200: serial bit rate in bits/s.
REQ-003 Derived CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer divide); elaboration SHALL fail if CLKS_PER_BIT < 4.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 urx_in  input  1  serial line, idle high, 8N1, LSB first; asynchronous to clk.
REQ-007 urx_valid  output  1  received byte available.
REQ-008 urx_data  output  8  received byte; stable while urx_valid high.
REQ-009 urx_ready  input  1  consumer accepts byte when urx_valid && urx_ready.
REQ-010 urx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 urx_overrun  output  1  one-cycle pulse: byte completed while holding register full.
REQ-012 urx_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 urx_in SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value (rx_s), reset value 1.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: on rx_s falling edge (previous 1, current 0) load bit counter with CLKS_PER_BIT/2 - 1, go START.
REQ-016 START: counter decrements each cycle; at 0 sample rx_s; if 1 (glitch) return IDLE with no outputs; if 0 load CLKS_PER_BIT - 1, bit index 0, go DATA.
REQ-017 DATA: at counter 0 shift rx_s into bit[index] (LSB first), reload CLKS_PER_BIT - 1; after index 7 go STOP.
REQ-018 STOP: at counter 0 sample rx_s; if 1 deliver byte and go IDLE immediately (mid-stop-bit), permitting back-to-back frames with zero idle time.
REQ-019 STOP sampled 0: pulse urx_frame_err one cycle, discard byte, go WAIT_HIGH; WAIT_HIGH returns to IDLE on first cycle rx_s = 1.
REQ-020 Byte delivery: if urx_valid low, or urx_valid && urx_ready in the same cycle, load urx_data and set urx_valid next cycle.
REQ-021 Byte delivery with urx_valid high and urx_ready low: pulse urx_overrun one cycle, drop new byte, keep held byte and urx_valid unchanged.
REQ-022 urx_valid SHALL clear the cycle after urx_valid && urx_ready with no simultaneous delivery; urx_data SHALL not change while urx_valid high except via REQ-020.
REQ-023 Latency: urx_valid rises 1 clk after the stop-bit mid-sample, i.e. about 9.5 bit times + 3 clks after the urx_in start edge.
REQ-024 Counters SHALL be sized $clog2(CLKS_PER_BIT) bits and never wrap outside the reload values above.
REQ-025 urx_frame_err and urx_overrun SHALL never both pulse in the same cycle.

Reset
REQ-026 While rst_n low: FSM IDLE, synchronizer flops 1, urx_valid 0, urx_data 8'h00, urx_frame_err 0, urx_overrun 0, urx_busy 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no byte or error output; after release, reception resumes only on a new falling edge.

Verification (CLOCK_FREQ=1600, BAUD_RATE=100, CLKS_PER_BIT=16)
REQ-028 Single frame 0x55, urx_ready=1 -> one urx_valid pulse, urx_data=0x55, no error pulses, urx_busy low after stop mid-sample.
REQ-029 Back-to-back 0xA5 then 0x3C, zero idle, urx_ready=1 -> two deliveries 0xA5, 0x3C in order.
REQ-030 urx_ready=0, send 0x11 then 0x22 -> urx_data held 0x11, one urx_overrun pulse on 0x22; urx_ready=1 -> 0x11 consumed, urx_valid 0.
REQ-031 Frame 0x7E with stop bit driven 0 for 3 bit times -> one urx_frame_err pulse, no urx_valid, urx_busy high until line returns 1.
REQ-032 urx_in low for 4 clks then high -> FSM returns IDLE from START, no outputs.
REQ-033 rst_n pulsed low during DATA bit 3 -> all outputs at reset values, next full frame 0xC3 received correctly.
